// File: rtl/datapath_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module  : datapath_cmd_queue
// Brief   : Command FIFO that feeds an external combinational datapath and
//           captures its result in a valid/ready output register.
// Rev     : 1.0  initial release
// ============================================================================
module datapath_cmd_queue #(
  parameter int N     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_A,
  input  logic [N-1:0]               in_B,
  input  logic [2:0]                 in_opcode,
  output logic [N-1:0]               dp_A,
  output logic [N-1:0]               dp_B,
  output logic [2:0]                 dp_opcode,
  input  logic [N-1:0]               dp_Y,
  input  logic                       dp_co,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_Y,
  output logic                       out_co,
  output logic [2:0]                 out_opcode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [N-1:0]  a_mem  [DEPTH];
  logic [N-1:0]  b_mem  [DEPTH];
  logic [2:0]    op_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          empty;
  logic          push;
  logic          issue;

  assign empty    = (count == '0);
  assign in_ready = (count < FULL_CNT) & ~rst;
  assign push     = in_valid & in_ready;
  // A result leaves the register the same cycle a new one may enter it.
  assign issue    = ~empty & (~out_valid | out_ready);

  always_comb begin
    dp_A      = '0;
    dp_B      = '0;
    dp_opcode = '0;
    if (!empty) begin
      dp_A      = a_mem[rd_ptr];
      dp_B      = b_mem[rd_ptr];
      dp_opcode = op_mem[rd_ptr];
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]  <= in_A;
      b_mem[wr_ptr]  <= in_B;
      op_mem[wr_ptr] <= in_opcode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_Y      <= '0;
      out_co     <= 1'b0;
      out_opcode <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr     <= rd_ptr + AW'(1);
        out_Y      <= dp_Y;
        out_co     <= dp_co;
        out_opcode <= op_mem[rd_ptr];
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_cmd_queue.sv
`default_nettype none
// Bench for datapath_cmd_queue: adder-stubbed datapath, queue-based reference model.
module tb_datapath_cmd_queue;

  localparam int N     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_A;
  logic [N-1:0]  in_B;
  logic [2:0]    in_opcode;
  logic [N-1:0]  dp_A;
  logic [N-1:0]  dp_B;
  logic [2:0]    dp_opcode;
  logic [N-1:0]  dp_Y;
  logic          dp_co;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_Y;
  logic          out_co;
  logic [2:0]    out_opcode;
  logic [CW-1:0] count;

  datapath_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_opcode(in_opcode),
    .dp_A(dp_A), .dp_B(dp_B), .dp_opcode(dp_opcode),
    .dp_Y(dp_Y), .dp_co(dp_co),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_Y(out_Y), .out_co(out_co), .out_opcode(out_opcode),
    .count(count)
  );

  assign {dp_co, dp_Y} = {1'b0, dp_A} + {1'b0, dp_B};

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
  } cmd_t;

  cmd_t         mq[$];
  logic         m_ov;
  logic [N-1:0] m_y;
  logic         m_co;
  logic [2:0]   m_op;

  int n_checks = 0;
  int n_fail   = 0;

  // Drive one cycle, advance the model by the queue rules, then sample at edge+1.
  task automatic step(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [2:0] op, input logic ordy, input logic r);
    cmd_t h;
    cmd_t c;
    logic acc;
    logic iss;
    logic [N:0] s;
    rst = r; in_valid = v; in_A = a; in_B = b; in_opcode = op; out_ready = ordy;
    if (r) begin
      mq.delete(); m_ov = 1'b0; m_y = '0; m_co = 1'b0; m_op = '0;
    end else begin
      acc = v && (mq.size() < DEPTH);
      iss = (mq.size() > 0) && (!m_ov || ordy);
      if (iss) begin
        h = mq.pop_front();
        s = {1'b0, h.a} + {1'b0, h.b};
        m_y = s[N-1:0]; m_co = s[N]; m_op = h.op; m_ov = 1'b1;
      end else if (m_ov && ordy) begin
        m_ov = 1'b0;
      end
      if (acc) begin
        c.a = a; c.b = b; c.op = op;
        mq.push_back(c);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 3) step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    in_A = '0; in_B = '0; in_opcode = '0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low: got %b want 0", in_ready); end
    step(1'b1, 16'd1, 16'd1, 3'd1, 1'b0, 1'b1);
    step(1'b1, 16'd1, 16'd1, 3'd1, 1'b0, 1'b1);
    n_checks++; if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_Y !== '0 || out_co !== 1'b0 || out_opcode !== '0)
      begin n_fail++; $display("FAIL rst_out_regs: got Y=%h co=%b op=%0d want 0/0/0", out_Y, out_co, out_opcode); end
    n_checks++; if (dp_A !== '0 || dp_B !== '0 || dp_opcode !== '0)
      begin n_fail++; $display("FAIL rst_dp_zero: got A=%h B=%h op=%0d want 0", dp_A, dp_B, dp_opcode); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    step(1'b1, 16'd5, 16'd3, 3'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || count !== CW'(1))
      begin n_fail++; $display("FAIL single_edge1: got valid=%b count=%0d want 0/1", out_valid, count); end
    n_checks++; if (dp_A !== 16'd5 || dp_B !== 16'd3)
      begin n_fail++; $display("FAIL single_dp_head: got A=%0d B=%0d want 5/3", dp_A, dp_B); end
    step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'd8 || out_co !== 1'b0 || out_opcode !== 3'd0)
      begin n_fail++; $display("FAIL single_result: got v=%b Y=%0d co=%b op=%0d want 1/8/0/0", out_valid, out_Y, out_co, out_opcode); end
    drain();
  endtask

  task automatic test_carry();
    step(1'b1, 16'hFFFF, 16'd1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 16'h7FFF, 16'd1, 3'd2, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'h0000 || out_co !== 1'b1 || out_opcode !== 3'd1)
      begin n_fail++; $display("FAIL carry_wrap: got v=%b Y=%h co=%b op=%0d want 1/0000/1/1", out_valid, out_Y, out_co, out_opcode); end
    step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || $signed(out_Y) !== -16'sd32768 || out_co !== 1'b0 || out_opcode !== 3'd2)
      begin n_fail++; $display("FAIL carry_ovf: got v=%b Y=%h co=%b op=%0d want 1/8000/0/2", out_valid, out_Y, out_co, out_opcode); end
    drain();
  endtask

  task automatic test_fill();
    int exp_y;
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 16'd10, 3'(i), 1'b0, 1'b0);
    n_checks++; if (count !== CW'(DEPTH) || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL fill_full: got count=%0d ready=%b want %0d/0", count, in_ready, DEPTH); end
    n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'd11)
      begin n_fail++; $display("FAIL fill_first: got v=%b Y=%0d want 1/11", out_valid, out_Y); end
    step(1'b1, 16'd99, 16'd99, 3'd7, 1'b0, 1'b0);
    n_checks++; if (count !== CW'(DEPTH) || out_Y !== 16'd11)
      begin n_fail++; $display("FAIL fill_refuse: got count=%0d Y=%0d want %0d/11", count, out_Y, DEPTH); end
    exp_y = 12;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'(exp_y) || out_opcode !== 3'(exp_y - 10))
        begin n_fail++; $display("FAIL fill_drain: got v=%b Y=%0d op=%0d want 1/%0d/%0d", out_valid, out_Y, out_opcode, exp_y, exp_y - 10); end
      exp_y++;
    end
    step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || count !== '0)
      begin n_fail++; $display("FAIL fill_empty: got v=%b count=%0d want 0/0", out_valid, count); end
  endtask

  task automatic test_stall();
    step(1'b1, 16'd100, 16'd23, 3'd5, 1'b0, 1'b0);
    step(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, '0, '0, 3'd0, 1'b0, 1'b0);
      n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'd123 || out_co !== 1'b0 || out_opcode !== 3'd5)
        begin n_fail++; $display("FAIL stall_hold: got v=%b Y=%0d co=%b op=%0d want 1/123/0/5", out_valid, out_Y, out_co, out_opcode); end
    end
    drain();
  endtask

  task automatic test_stream();
    int seen;
    int max_cnt;
    seen = 0; max_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) step(1'b1, 16'(i), 16'(i), 3'(i), 1'b1, 1'b0);
      else       step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (i >= 1 && i <= 8) begin
        n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'(2 * seen))
          begin n_fail++; $display("FAIL stream_result: got v=%b Y=%0d want 1/%0d", out_valid, out_Y, 2 * seen); end
        seen++;
      end
    end
    n_checks++; if (max_cnt > 1) begin n_fail++; $display("FAIL stream_count: got max %0d want <=1", max_cnt); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got v=%b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1'b1, 16'(i + 1), 16'd1, 3'd3, 1'b0, 1'b0);
    n_checks++; if (count !== CW'(3) || out_valid !== 1'b1)
      begin n_fail++; $display("FAIL rmid_pre: got count=%0d v=%b want 3/1", count, out_valid); end
    step(1'b1, 16'd50, 16'd50, 3'd6, 1'b1, 1'b1);
    n_checks++; if (count !== '0 || out_valid !== 1'b0 || out_Y !== '0)
      begin n_fail++; $display("FAIL rmid_clear: got count=%0d v=%b Y=%0d want 0/0/0", count, out_valid, out_Y); end
    step(1'b1, 16'd7, 16'd2, 3'd4, 1'b1, 1'b0);
    step(1'b0, '0, '0, 3'd0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b1 || out_Y !== 16'd9 || out_opcode !== 3'd4)
      begin n_fail++; $display("FAIL rmid_after: got v=%b Y=%0d op=%0d want 1/9/4", out_valid, out_Y, out_opcode); end
    drain();
  endtask

  task automatic test_random();
    logic v;
    logic ordy;
    for (int i = 0; i < 400; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(v, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), ordy, 1'b0);
      n_checks++; if (count !== CW'(mq.size()) || in_ready !== (mq.size() < DEPTH))
        begin n_fail++; $display("FAIL rand_count: cyc %0d got count=%0d ready=%b want %0d", i, count, in_ready, mq.size()); end
      n_checks++; if (out_valid !== m_ov)
        begin n_fail++; $display("FAIL rand_valid: cyc %0d got %b want %b", i, out_valid, m_ov); end
      if (m_ov) begin
        n_checks++; if (out_Y !== m_y || out_co !== m_co || out_opcode !== m_op)
          begin n_fail++; $display("FAIL rand_result: cyc %0d got Y=%h co=%b op=%0d want %h/%b/%0d", i, out_Y, out_co, out_opcode, m_y, m_co, m_op); end
      end
      if (mq.size() > 0) begin
        n_checks++; if (dp_A !== mq[0].a || dp_B !== mq[0].b || dp_opcode !== mq[0].op)
          begin n_fail++; $display("FAIL rand_head: cyc %0d got A=%h B=%h op=%0d want %h/%h/%0d", i, dp_A, dp_B, dp_opcode, mq[0].a, mq[0].b, mq[0].op); end
      end
    end
    drain();
    n_checks++; if (count !== '0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL rand_drained: got count=%0d v=%b want 0/0", count, out_valid); end
  endtask

  initial begin
    m_ov = 1'b0; m_y = '0; m_co = 1'b0; m_op = '0;
    test_reset();
    test_single();
    test_carry();
    test_fill();
    test_stall();
    test_stream();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/datapath_cmd_queue.md
DATAPATH_CMD_QUEUE -- requirements
Module: datapath_cmd_queue

Interface
REQ-001 Parameter N, default 16: operand/result width in bits, two's complement signed.
REQ-002 Parameter DEPTH, default 4: command FIFO entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream command present.
REQ-006 in_ready  output  1  queue can accept a command this cycle.
REQ-007 in_A  input  N  signed operand A.
REQ-008 in_B  input  N  signed operand B.
REQ-009 in_opcode  input  3  operation select.
REQ-010 dp_A  output  N  operand A to the arithmetic datapath.
REQ-011 dp_B  output  N  operand B to the arithmetic datapath.
REQ-012 dp_opcode  output  3  opcode to the arithmetic datapath.
REQ-013 dp_Y  input  N  combinational datapath result for dp_A/dp_B/dp_opcode.
REQ-014 dp_co  input  1  combinational datapath carry-out.
REQ-015 out_valid  output  1  result register holds an unconsumed result.
REQ-016 out_ready  input  1  downstream accepts result this cycle.
REQ-017 out_Y  output  N  registered result.
REQ-018 out_co  output  1  registered carry-out.
REQ-019 out_opcode  output  3  opcode that produced out_Y.
REQ-020 count  output  $clog2(DEPTH)+1  number of queued, not-yet-issued commands.

Function
REQ-021 Push: in_valid & in_ready at an edge writes {in_A,in_B,in_opcode} at the tail; count+1.
REQ-022 in_ready SHALL be (count < DEPTH) & !rst; no push when full, even if a pop occurs the same cycle.
REQ-023 dp_A/dp_B/dp_opcode SHALL combinationally reflect the head entry when count>0; all-zero when count==0.
REQ-024 Issue condition: count>0 & (!out_valid | out_ready).
REQ-025 On issue at an edge: out_Y<=dp_Y, out_co<=dp_co, out_opcode<=head opcode, out_valid<=1, head pops, count-1.
REQ-026 out_valid & out_ready with no issue at that edge: out_valid<=0; out_Y/out_co/out_opcode hold.
REQ-027 Stall: while out_valid & !out_ready, out_Y/out_co/out_opcode SHALL be stable and no pop occurs.
REQ-028 Simultaneous push and issue: count unchanged; pointers both advance.
REQ-029 Latency: command pushed at edge t into empty queue with free output register -> out_valid high after edge t+1.
REQ-030 Throughput: one result per cycle sustained when out_ready held high and in_valid held high.
REQ-031 Order: results SHALL leave in push order; no drop, no duplication.
REQ-032 Pointers SHALL wrap modulo DEPTH; count distinguishes full (DEPTH) from empty (0).
REQ-033 Block SHALL NOT alter dp_Y width or sign; out_Y is a bit-exact copy.

Reset
REQ-034 rst high at an edge: count=0, pointers=0, out_valid=0, out_Y=0, out_co=0, out_opcode=0.
REQ-035 rst mid-operation discards queued commands and any pending result; no push or issue at that edge.
REQ-036 in_ready SHALL be 0 while rst is high, 1 in the first cycle after rst deasserts.

Verification (bench stubs datapath: dp_Y = dp_A+dp_B truncated to N, dp_co = carry-out of the unsigned N-bit sum)
REQ-037 Single op: push A=5,B=3,op=000, out_ready=1 -> out_valid after 2nd edge, out_Y=8, out_co=0, out_opcode=000.
REQ-038 Carry/wrap: push A=-1 (0xFFFF), B=1 -> out_Y=0, out_co=1; A=32767,B=1 -> out_Y=-32768, out_co=0.
REQ-039 Fill: out_ready=0, push 5 commands (A=1..5,B=10) -> 1 issues to result reg, count reaches 4, in_ready=0, 6th push refused; release out_ready -> out_Y sequence 11,12,13,14,15.
REQ-040 Stall stability: out_valid=1, out_ready=0 for 3 cycles -> out_Y/out_co/out_opcode unchanged each cycle.
REQ-041 Streaming: in_valid=1, out_ready=1, 8 pushes A=i,B=i -> 8 results 2i in order, one per cycle, count never exceeds 1.
REQ-042 Reset mid-stream: count=3, out_valid=1, assert rst 1 cycle -> count=0, out_valid=0, out_Y=0; next push A=7,B=2 -> out_Y=9.
